linear_embed_ctrl: RTL
======================

// Module: linear_embed_ctrl
// PURPOSE
//  Sequencer for the linear-embedding dot-product datapath of the ECG classifier.
//  Loads wt/bias/cls_token (16 x Q4.4 each) from the parameter ROM into the datapath registers.
//  Accepts one 15-sample ECG segment per valid/ready handshake and fires a one-cycle start.
//  Waits for the datapath done, then holds the 16x16 token matrix valid until downstream accepts it.
// PARAMETERS
//  D_MODEL  16    embedding width; entries per parameter vector
//  ROM_AW   6     parameter ROM address width
//  TIMEOUT  1024  max RUN cycles before abort; >= 2
//  CNT_W    16    segment counter width
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        async active-high reset
//  reload       in   1        pulse: re-read all parameters from ROM
//  seg_valid    in   1        upstream ECG segment available
//  seg_ready    out  1        segment accepted this cycle when seg_valid & seg_ready
//  rom_en       out  1        ROM read enable; data returns next cycle
//  rom_addr     out  ROM_AW   ROM address: wt 0..15, bias 16..31, cls 32..47
//  rom_rdata    in   8        ROM read data (Q4.4)
//  prm_we       out  1        parameter register write strobe
//  prm_sel      out  2        0=wt, 1=bias, 2=cls_token; 3 unused
//  prm_idx      out  4        element index 0..15
//  prm_wdata    out  8        parameter value (rom_rdata, passed through)
//  emb_start    out  1        one-cycle start pulse to the datapath
//  emb_done     in   1        datapath completion pulse
//  out_valid    out  1        token matrix valid downstream
//  out_ready    in   1        downstream accepts the matrix
//  busy         out  1        state != IDLE
//  timeout_err  out  1        sticky: a RUN phase timed out
//  seg_count    out  CNT_W    completed segments; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE, params_ok=0, reload_pend=0, counters=0. All outputs 0.
//  Exception: seg_ready follows its rule below, so it is 0 while params_ok=0.
//  FSM states: IDLE, LOAD, START, RUN, HOLD.
//  IDLE -> LOAD when !params_ok | reload | reload_pend.
//   Else, with seg_valid, IDLE -> START.
//   seg_ready = (state==IDLE) & params_ok & !reload & !reload_pend (combinational).
//  LOAD: k counts 0..47 with rom_en=1 and rom_addr=k.
//   The cycle after each read: prm_we=1, prm_sel=k_d/16, prm_idx=k_d%16, prm_wdata=rom_rdata.
//   (k_d = k delayed one cycle.)
//   Total 49 cycles, 48 writes, then params_ok=1, reload_pend=0, timeout_err=0 -> IDLE.
//  START: emb_start=1 for exactly 1 cycle -> RUN; the RUN cycle counter clears.
//  RUN: on emb_done -> HOLD.
//   Otherwise, when the counter reaches TIMEOUT-1 -> IDLE with timeout_err=1; no out_valid.
//  HOLD: out_valid=1 until out_ready. In the out_ready cycle: seg_count++ -> IDLE.
//  Back-to-back: a new segment is accepted no earlier than the cycle after HOLD exits.
//  emb_done outside RUN is ignored.
//  emb_done in the same cycle as the timeout: done wins -> HOLD.
//  reload outside IDLE sets reload_pend. It is served on the next IDLE, ahead of any segment.
//  reload during LOAD is absorbed; the load continues and is not restarted.
//  reload together with seg_valid in IDLE: reload wins; the segment is not accepted.
//  rst mid-operation (any state): immediate return to the reset values.
//   params_ok clears, so a full reload follows.
//   A partially written parameter set is invalid until that reload completes.
//  seg_count wraps 0xFFFF -> 0x0000 silently.
// STRUCTURE
//  Package linear_embed_pkg holds:
//   - the state_t enum (IDLE, LOAD, START, RUN, HOLD)
//   - the prm_sel encodings PRM_WT, PRM_BIAS, PRM_CLS
//   - the ROM base constants WT_BASE=0, BIAS_BASE=16, CLS_BASE=32, PRM_WORDS=48.
//  Sub-module embed_param_loader handles the LOAD phase.
//   It holds the address counter, the one-cycle write pipeline and a load_done pulse.
//   Handshake: start in, load_done out; it drives the rom_* and prm_* ports.
//  The FSM, timeout counter and seg_count stay in the top module.
// TESTING
//  1. Release rst; ROM word k = k+1.
//     -> 48 prm_we strobes, the first at cycle 2 after leaving IDLE.
//     -> (sel,idx,wdata) = (0,0,0x01) .. (2,15,0x30); then seg_ready=1.
//  2. seg_valid=1; model emb_done 241 cycles after emb_start; out_ready low for 5 cycles.
//     -> emb_start high for exactly 1 cycle; out_valid held 6 cycles.
//     -> seg_count 0->1; busy=0 after.
//  3. TIMEOUT=64; emb_done never asserted.
//     -> IDLE after 64 RUN cycles; timeout_err=1; out_valid never set.
//     -> A following reload clears timeout_err.
//  4. reload and seg_valid together in IDLE -> seg_ready=0; a full 49-cycle LOAD runs, then the segment is accepted.
//     reload pulsed in RUN -> LOAD directly after HOLD.
//  5. Assert rst at RUN cycle 10.
//     -> All outputs 0 immediately; params_ok=0; full reload after release.
//     -> A stale emb_done is ignored.
//  6. Force seg_count=0xFFFF and complete one segment -> seg_count=0x0000, no error.

Source files
------------

// File: rtl/linear_embed_pkg.sv
// Shared types and constants for the linear-embedding sequencer.
package linear_embed_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        HOLD
    } state_t;

    localparam logic [1:0] PRM_WT   = 2'd0;
    localparam logic [1:0] PRM_BIAS = 2'd1;
    localparam logic [1:0] PRM_CLS  = 2'd2;

    localparam int WT_BASE   = 0;
    localparam int BIAS_BASE = 16;
    localparam int CLS_BASE  = 32;
    localparam int PRM_WORDS = 48;

    function automatic logic [1:0] prm_sel_of(input int k);
        logic [1:0] sel;
        sel = PRM_WT;
        if (k >= CLS_BASE) begin
            sel = PRM_CLS;
        end else if (k >= BIAS_BASE) begin
            sel = PRM_BIAS;
        end
        return sel;
    endfunction

endpackage

// File: rtl/linear_embed_if.sv
// Segment, ROM, parameter-write, datapath and token-matrix signals
// seen by the embedding sequencer.
interface linear_embed_if #(
    parameter int ROM_AW = 6
);
    logic              seg_valid;
    logic              seg_ready;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_rdata;
    logic              prm_we;
    logic [1:0]        prm_sel;
    logic [3:0]        prm_idx;
    logic [7:0]        prm_wdata;
    logic              emb_start;
    logic              emb_done;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  seg_valid, rom_rdata, emb_done, out_ready,
        output seg_ready, rom_en, rom_addr,
        output prm_we, prm_sel, prm_idx, prm_wdata,
        output emb_start, out_valid
    );

    modport slave (
        output seg_valid, rom_rdata, emb_done, out_ready,
        input  seg_ready, rom_en, rom_addr,
        input  prm_we, prm_sel, prm_idx, prm_wdata,
        input  emb_start, out_valid
    );
endinterface

// File: rtl/linear_embed_ctrl_loader.sv
// Streams wt/bias/cls_token from the parameter ROM into the datapath
// registers; each ROM word is written one cycle after its read.
module embed_param_loader
    import linear_embed_pkg::*;
#(
    parameter int ROM_AW  = 6,
    parameter int D_MODEL = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              load_done_o,
    output logic              rom_en_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [7:0]        rom_rdata_i,
    output logic              prm_we_o,
    output logic [1:0]        prm_sel_o,
    output logic [3:0]        prm_idx_o,
    output logic [7:0]        prm_wdata_o
);
    localparam logic [5:0] K_LAST = 6'(PRM_WORDS - 1);

    logic       run_q;
    logic       we_q;
    logic [5:0] k_q;
    logic [5:0] kd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            we_q  <= 1'b0;
            k_q   <= '0;
            kd_q  <= '0;
        end else begin
            we_q <= run_q;
            kd_q <= k_q;
            if (start_i) begin
                run_q <= 1'b1;
                k_q   <= '0;
            end else if (run_q) begin
                k_q <= k_q + 6'd1;
                if (k_q == K_LAST) begin
                    run_q <= 1'b0;
                end
            end
        end
    end

    assign rom_en_o    = run_q;
    assign rom_addr_o  = run_q ? ROM_AW'(WT_BASE + int'(k_q)) : '0;
    assign prm_we_o    = we_q;
    // Outputs are gated so the write port idles at zero between loads
    assign prm_sel_o   = we_q ? prm_sel_of(int'(kd_q)) : '0;
    assign prm_idx_o   = we_q ? 4'(int'(kd_q) % D_MODEL) : '0;
    assign prm_wdata_o = we_q ? rom_rdata_i : '0;
    assign load_done_o = we_q && (kd_q == K_LAST);

endmodule

// File: rtl/linear_embed_ctrl.sv
// Sequencer for the ECG linear-embedding datapath: parameter load,
// per-segment start/run/hold with RUN timeout and segment counting.
module linear_embed_ctrl
    import linear_embed_pkg::*;
#(
    parameter int D_MODEL = 16,
    parameter int ROM_AW  = 6,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reload,
    linear_embed_if.master   bus,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] seg_count
);
    localparam int             TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             params_ok_q, params_ok_d;
    logic             pend_q, pend_d;
    logic             terr_q, terr_d;
    logic [TW-1:0]    run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld_start;
    logic             ld_done;

    embed_param_loader #(
        .ROM_AW  (ROM_AW),
        .D_MODEL (D_MODEL)
    ) u_loader (
        .clk         (clk),
        .rst         (rst),
        .start_i     (ld_start),
        .load_done_o (ld_done),
        .rom_en_o    (bus.rom_en),
        .rom_addr_o  (bus.rom_addr),
        .rom_rdata_i (bus.rom_rdata),
        .prm_we_o    (bus.prm_we),
        .prm_sel_o   (bus.prm_sel),
        .prm_idx_o   (bus.prm_idx),
        .prm_wdata_o (bus.prm_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            params_ok_q <= 1'b0;
            pend_q      <= 1'b0;
            terr_q      <= 1'b0;
            run_cnt_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            params_ok_q <= params_ok_d;
            pend_q      <= pend_d;
            terr_q      <= terr_d;
            run_cnt_q   <= run_cnt_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        params_ok_d   = params_ok_q;
        pend_d        = pend_q;
        terr_d        = terr_q;
        run_cnt_d     = run_cnt_q;
        cnt_d         = cnt_q;
        ld_start      = 1'b0;
        bus.seg_ready = 1'b0;
        bus.emb_start = 1'b0;
        bus.out_valid = 1'b0;

        // A reload that lands mid-load is absorbed by the running load
        if (reload && state_q != IDLE && state_q != LOAD) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (!params_ok_q || reload || pend_q) begin
                    state_d  = LOAD;
                    ld_start = 1'b1;
                end else begin
                    bus.seg_ready = 1'b1;
                    if (bus.seg_valid) begin
                        state_d = START;
                    end
                end
            end
            LOAD: begin
                if (ld_done) begin
                    state_d     = IDLE;
                    params_ok_d = 1'b1;
                    pend_d      = 1'b0;
                    terr_d      = 1'b0;
                end
            end
            START: begin
                bus.emb_start = 1'b1;
                run_cnt_d     = '0;
                state_d       = RUN;
            end
            RUN: begin
                if (bus.emb_done) begin
                    state_d = HOLD;
                end else if (run_cnt_q == T_LAST) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;
    assign seg_count   = cnt_q;

endmodule
